tanh_act_arbiter: RTL and testbench

Round-robin scheduler that shares one 4-bit approximate tanh activation datapath among NREQ requesters, such as neuron lanes in an activation stage. Each requester uses a valid/ready request port. The block grants at most one request per cycle into a two-stage registered pipeline and returns each result with the originating requester's ID. Results are returned in issue order through a valid/ready response port.

---
 rtl/tanh_act_if.sv | 24 ++
 rtl/tanh_act_arbiter.sv | 112 +++++++++++
 tb/tb_tanh_act_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tanh_act_if.sv
// Request/response bundle between NREQ activation requesters and the shared tanh unit.
interface tanh_act_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [3:0]        rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_ready;
  logic              busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/tanh_act_arbiter.sv
// Shares one 4-bit approximate tanh datapath among NREQ requesters through a 2-stage pipeline.
// Define TANH_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module tanh_act_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input logic       clk,
  input logic       rst,
  tanh_act_if.slave bus
);
  localparam int DATA_W = 4;

  logic              vld_p1, vld_p2;
  logic [DATA_W-1:0] op_p1, y_p2;
  logic [ID_W-1:0]   id_p1, id_p2;

  logic              s1_free, s2_free;
  logic              gnt_any, take;
  logic [ID_W-1:0]   gnt_idx;
  logic [NREQ-1:0]   gnt_vec;
  logic [DATA_W-1:0] gnt_data;

  function automatic logic [DATA_W-1:0] tanh_approx(input logic [DATA_W-1:0] x);
    logic t;
    t = x[3] & x[2] & ~x[1] & ~x[0];
    return {x[1] ^ t, x[1] ^ t, x[0], x[0]};
  endfunction

  assign s2_free = !vld_p2 || bus.rsp_ready;
  assign s1_free = !vld_p1 || s2_free;

`ifdef TANH_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   cand;

  // Scan offsets from the far end so the nearest valid requester after ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NREQ)) cand = cand - (ID_W+1)'(NREQ);
      if (bus.req_valid[cand[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end
`endif

  // Grant is suppressed while reset is asserted so req_ready reads 0 immediately.
  always_comb begin
    gnt_vec = '0;
    if (!rst && s1_free && gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  assign take     = |gnt_vec;
  assign gnt_data = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];

  // ---- p0 -> p1: issue register ----
  always_ff @(posedge clk) begin
    if (take) begin
      op_p1 <= gnt_data;
      id_p1 <= gnt_idx;
    end
  end

  // ---- p1 -> p2: tanh evaluated on the way into the result register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      y_p2   <= '0;
      id_p2  <= '0;
    end else begin
      if (s1_free) vld_p1 <= take;
      if (s2_free) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          y_p2  <= tanh_approx(op_p1);
          id_p2 <= id_p1;
        end
      end
    end
  end

  assign bus.req_ready = gnt_vec;
  assign bus.rsp_valid = vld_p2;
  assign bus.rsp_data  = y_p2;
  assign bus.rsp_id    = id_p2;
  assign bus.busy      = vld_p1 | vld_p2;
endmodule

// File: tb/tb_tanh_act_arbiter.sv
// Randomized scoreboard bench for tanh_act_arbiter with a transaction-level reference model.
module tb_tanh_act_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tanh_act_if #(.NREQ(NREQ), .ID_W(ID_W)) ifc ();

  tanh_act_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct {
    int id;
    int y;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [NREQ-1:0] v;
  logic [3:0]      d [NREQ];
  logic [NREQ-1:0] acc;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
  endtask

  // Only operand 1100 is special; otherwise each result pair copies one operand bit.
  function automatic int tanh_ref(input int x);
    if (x == 12) return 12;
    return ((x >> 1) & 1) * 12 + (x & 1) * 3;
  endfunction

  // Reference model: pipeline occupancy, pointer and expected grant per cycle.
  bit m1, m2;
  int mptr;
  always @(negedge clk) begin : model
    bit s1f, s2f;
    int g;
    logic [NREQ-1:0] expv;
    if (rst) begin
      m1 = 0; m2 = 0; mptr = 0;
      sb.delete();
    end else begin
      s2f = !m2 || ifc.rsp_ready;
      s1f = !m1 || s2f;
      g = -1;
      if (s1f) begin
        for (int k = 0; k < NREQ; k++) begin
`ifdef TANH_ARB_FIXED_PRIO_EN
          if (g < 0 && ifc.req_valid[k]) g = k;
`else
          if (g < 0 && ifc.req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
`endif
        end
      end
      expv = '0;
      if (g >= 0) expv[g] = 1'b1;
      chk("req_ready", int'(ifc.req_ready), int'(expv));
      chk("rsp_valid", int'(ifc.rsp_valid), int'(m2));
      chk("busy", int'(ifc.busy), int'(m1 | m2));
      if (g >= 0) sb.push_back('{g, tanh_ref(int'(ifc.req_data[4*g +: 4]))});
      if (s2f) m2 = m1;
      if (s1f) m1 = (g >= 0);
      if (g >= 0) mptr = (g + 1) % NREQ;
    end
  end

  // Monitor: pops on each accepted response and checks hold stability under backpressure.
  bit         stall;
  logic [3:0] hd;
  logic [1:0] hi;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      stall = 0;
    end else begin
      if (stall) begin
        chk("hold_data", int'(ifc.rsp_data), int'(hd));
        chk("hold_id", int'(ifc.rsp_id), int'(hi));
      end
      if (ifc.rsp_valid && ifc.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", int'(ifc.rsp_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", int'(ifc.rsp_data), e.y);
          chk("rsp_id", int'(ifc.rsp_id), e.id);
        end
      end
      stall = ifc.rsp_valid && !ifc.rsp_ready;
      hd = ifc.rsp_data;
      hi = ifc.rsp_id;
    end
  end

  task automatic apply();
    ifc.req_valid = v;
    for (int i = 0; i < NREQ; i++) ifc.req_data[4*i +: 4] = d[i];
  endtask

  task automatic step();
    @(negedge clk);
    acc = ifc.req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic refresh_accepted();
    for (int i = 0; i < NREQ; i++) if (acc[i]) d[i] = 4'($urandom_range(0, 15));
    apply();
  endtask

  task automatic rand_cycle(input int pv, input int pr);
    step();
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && !acc[i]) begin
        if ($urandom_range(0, 99) < 5) v[i] = 1'b0;
      end else begin
        v[i] = ($urandom_range(0, 99) < pv);
        d[i] = 4'($urandom_range(0, 15));
      end
    end
    ifc.rsp_ready = ($urandom_range(0, 99) < pr);
    apply();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int cnt;
    bit got;
    rst = 1'b1;
    v   = '0;
    acc = '0;
    for (int i = 0; i < NREQ; i++) d[i] = '0;
    ifc.rsp_ready = 1'b0;
    apply();
    #12;
    chk("rst_req_ready", int'(ifc.req_ready), 0);
    chk("rst_rsp_valid", int'(ifc.rsp_valid), 0);
    chk("rst_rsp_data", int'(ifc.rsp_data), 0);
    chk("rst_rsp_id", int'(ifc.rsp_id), 0);
    chk("rst_busy", int'(ifc.busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request from requester 2.
    ifc.rsp_ready = 1'b1;
    v = 4'b0100;
    d[2] = 4'b1100;
    apply();
    step();
    chk("single_grant", int'(acc), 4);
    v = '0;
    apply();
    repeat (4) step();

    // Operand sweep through requester 0.
    for (int x = 0; x < 16; x++) begin
      v = 4'b0001;
      d[0] = 4'(x);
      apply();
      got = 0;
      for (int t = 0; t < 8 && !got; t++) begin
        step();
        got = acc[0];
      end
      chk("sweep_accepted", int'(got), 1);
    end
    v = '0;
    apply();
    repeat (4) step();

    // All requesters continuously valid.
    v = '1;
    apply();
    repeat (16) begin
      step();
      refresh_accepted();
    end
    v = '0;
    apply();
    repeat (4) step();

    // Backpressure from an empty pipeline.
    v = '1;
    ifc.rsp_ready = 1'b0;
    apply();
    cnt = 0;
    repeat (5) begin
      step();
      cnt += $countones(acc);
      refresh_accepted();
    end
    chk("stall_accepts", cnt, 2);
    ifc.rsp_ready = 1'b1;
    repeat (6) begin
      step();
      refresh_accepted();
    end
    v = '0;
    apply();
    repeat (4) step();

    // Random traffic with random backpressure.
    repeat (400) rand_cycle(60, 70);
    v = '0;
    ifc.rsp_ready = 1'b1;
    apply();
    repeat (4) step();

    // Reset with both stages full.
    v = '1;
    ifc.rsp_ready = 1'b0;
    apply();
    repeat (3) begin
      step();
      refresh_accepted();
    end
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", int'(ifc.rsp_valid), 0);
    chk("midrst_busy", int'(ifc.busy), 0);
    chk("midrst_req_ready", int'(ifc.req_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_grant", int'(ifc.req_ready), 1);
    ifc.rsp_ready = 1'b1;
    repeat (6) begin
      step();
      refresh_accepted();
    end
    v = '0;
    apply();
    repeat (5) step();
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
